vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; next generation of the fixed 640x480 sync generator.
- Drives hsync/vsync/display-enable and pixel coordinates to the video back end (pixel colour logic, framebuffer read).
- Adds over the fixed generator: configurable porch/sync/active widths and sync polarity, a pixel clock-enable, exact-width sync pulses, fully aligned registered outputs, blanking flags and frame/line start strobes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync asserted level (0 = active-low)
- V_SYNC_POL, 0, vsync asserted level (0 = active-low)
- CNT_W, 10, counter/coordinate width; must hold max(H_TOTAL, V_TOTAL) - 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_ce  in  1  pixel advance enable; tie high for one pixel per clk
- hsync  out  1  horizontal sync, at H_SYNC_POL when asserted
- vsync  out  1  vertical sync, at V_SYNC_POL when asserted
- de  out  1  display enable; high when the pixel is inside the active area
- hblank  out  1  high when x >= H_ACTIVE
- vblank  out  1  high when y >= V_ACTIVE
- x  out  CNT_W  current pixel column, 0..H_TOTAL-1
- y  out  CNT_W  current line, 0..V_TOTAL-1
- line_start  out  1  one-clk strobe when x becomes 0
- frame_start  out  1  one-clk strobe when (x, y) becomes (0, 0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 800); V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (default 525).
- Counters:
  - Internal h_cnt counts 0..H_TOTAL-1 exactly, with no extra count.
  - v_cnt increments only when h_cnt wraps; it counts 0..V_TOTAL-1, then returns to 0.
  - Both advance only on clk edges where pix_ce = 1.
- Decode windows:
  - hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]: exactly H_SYNC pixels.
  - vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]: exactly V_SYNC whole lines, changing together with the h_cnt = 0 pixel.
  - de = !hblank && !vblank.
- Output registers:
  - All outputs are registered.
  - On a pix_ce = 1 edge, the output regs load the decode of the pre-increment counter values.
  - Result: x, y, de, hsync, vsync, hblank and vblank always describe the same pixel, one pixel behind the internal counters.
  - On pix_ce = 0, all level outputs hold.
- Strobes:
  - line_start and frame_start go high on the pix_ce edge that loads x = 0 (resp. x = 0 and y = 0).
  - They are cleared on the next clk edge regardless of pix_ce, so each strobe is exactly one clk wide.
- Reset:
  - Counters 0; x = y = 0; de = 0; hblank = vblank = 0.
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL; strobes 0.
  - rst has priority over pix_ce.
  - Reset mid-frame restarts the raster at (0, 0) with no partial sync pulse beyond the reset edge.
- First pix_ce edge after reset loads (0, 0): de = 1, line_start = frame_start = 1.
- Wrap: the pixel after (H_TOTAL-1, V_TOTAL-1) is (0, 0) with frame_start.
- Elaboration: generate a $error if any porch, sync or active parameter is 0, or if CNT_W is too small.

Optional Feature:
- Macro: VGA_TIMING_LINE_IRQ_EN.
- When defined:
  - Adds input irq_line [CNT_W-1:0] and output line_irq.
  - line_irq is a one-clk strobe on the pix_ce edge that loads x = H_ACTIVE with y == irq_line, i.e. start of hblank on that line.
  - irq_line is sampled at that edge.
  - irq_line >= V_TOTAL never fires.
  - line_irq resets to 0.
- When undefined: both ports are absent and no logic is generated.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 constants (H_*/V_* values above);
  - an optional 800x600 constant set;
  - helper functions total(active, fp, sync, bp) and sync_window(cnt, start, width).
- One sub-module, vga_axis_counter, is instantiated twice (horizontal, vertical).
  - Parameters: ACTIVE, FP, SYNC, BP, CNT_W.
  - Inputs: clk, rst, adv.
  - Outputs: cnt, wrap, blank, sync_act.
  - The vertical instance's adv = pix_ce && h wrap.

Test Plan:
- Defaults, pix_ce = 1, run 2 frames → line_start period 800 clk; frame_start period 420000 clk; de high 307200 clk per frame; x max 799; y max 524.
- Defaults → hsync low for exactly 96 consecutive pixels starting at x = 656; vsync low for exactly 2 lines (1600 clk) starting at y = 490, x = 0.
- pix_ce toggled 1,0,1,0… → all level outputs change only every 2nd clk; frame period 840000 clk; strobes still one clk wide.
- rst asserted at (x = 300, y = 200) for 3 clk → outputs at reset values during rst; first pix_ce edge after release gives x = 0, y = 0, frame_start = 1.
- Parameters H 8/2/2/2, V 4/1/1/1, H_SYNC_POL = V_SYNC_POL = 1 → H_TOTAL 14, V_TOTAL 7; hsync high at x = 10..11; vsync high at y = 5; reset levels hsync = vsync = 0.
- VGA_TIMING_LINE_IRQ_EN, irq_line = 100 → exactly one line_irq per frame, coincident with x = 640, y = 100; irq_line = 600 → none.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator.
// The default 640x480@60 set is used by vga_timing_gen; the 800x600@60 set is
// available for instances that override the generator parameters.
package vga_timing_pkg;

  // 640x480@60 (25.175 MHz pixel clock), negative sync polarity
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_H_POL    = 1'b0;
  localparam bit VGA640_V_POL    = 1'b0;

  // 800x600@60 (40 MHz pixel clock), positive sync polarity
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_H_POL    = 1'b1;
  localparam bit SVGA800_V_POL    = 1'b1;

  // Total number of counts on one axis (pixels per line or lines per frame)
  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // True when cnt lies inside the sync pulse [start, start + width - 1]
  function automatic logic sync_window(input int cnt, input int start, input int width);
    return (cnt >= start) && (cnt < start + width);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus blank and sync decodes of
// the current count. Used once for pixels within a line and once for lines
// within a frame.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             blank,
  output logic             sync_act
);

  localparam int TOTAL      = total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_START = ACTIVE + FP;
  localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(ACTIVE);

  logic at_last;

  assign at_last  = (cnt == LAST);
  assign wrap     = adv && at_last;
  assign blank    = (cnt >= BLANK_START);
  assign sync_act = sync_window(int'(cnt), SYNC_START, SYNC);

  // Count 0..TOTAL-1 and return to 0, advancing only when adv is high
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= at_last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: hsync/vsync/de, blanking flags, pixel
// coordinates and line/frame start strobes, all registered and describing the
// same pixel. Optional feature macro VGA_TIMING_LINE_IRQ_EN adds irq_line and
// a line_irq strobe at the start of hblank on the selected line.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FP       = VGA640_H_FP,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BP       = VGA640_H_BP,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FP       = VGA640_V_FP,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BP       = VGA640_V_BP,
  parameter bit H_SYNC_POL = VGA640_H_POL,
  parameter bit V_SYNC_POL = VGA640_V_POL,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [CNT_W-1:0] irq_line,
  output logic             line_irq,
`endif
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             hblank,
  output logic             vblank,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int MAX_CNT = ((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL) - 1;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: every active, porch and sync width must be non-zero");
  end

  if (CNT_W < 1 || (CNT_W < 31 && MAX_CNT >= (1 << CNT_W))) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too small for the largest raster count");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_blank;
  logic             v_blank;
  logic             h_sync_act;
  logic             v_sync_act;
  logic             v_adv;
  logic             at_origin;

  assign v_adv = pix_ce && h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .adv      (pix_ce),
    .cnt      (h_cnt),
    .wrap     (h_wrap),
    .blank    (h_blank),
    .sync_act (h_sync_act)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .adv      (v_adv),
    .cnt      (v_cnt),
    .wrap     (v_wrap),
    .blank    (v_blank),
    .sync_act (v_sync_act)
  );

  // Track whether the counters sit at (0, 0): true after reset or a frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      at_origin <= 1'b1;
    end else if (pix_ce) begin
      at_origin <= v_wrap;
    end
  end

  // Register the decode of the pre-increment counters; strobes last one clk
  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= !H_SYNC_POL;
      vsync       <= !V_SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        x           <= h_cnt;
        y           <= v_cnt;
        hblank      <= h_blank;
        vblank      <= v_blank;
        de          <= !h_blank && !v_blank;
        hsync       <= h_sync_act ? H_SYNC_POL : !H_SYNC_POL;
        vsync       <= v_sync_act ? V_SYNC_POL : !V_SYNC_POL;
        line_start  <= (h_cnt == '0);
        frame_start <= at_origin;
      end
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  localparam logic [CNT_W-1:0] IRQ_X = CNT_W'(H_ACTIVE);

  // Fire once when the pixel entering hblank on the selected line is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      line_irq <= 1'b0;
    end else begin
      line_irq <= pix_ce && (h_cnt == IRQ_X) && (v_cnt == irq_line);
    end
  end
`endif

endmodule
